// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: 2-entry IF/ID skid buffer with NOP injection; optional perf counters under IFID_PERF_CNT_EN
module if_id_skid_reg #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_inst,
  input  logic [15:0] if_pcadd2,
  input  logic        id_stall,
  input  logic        flush,
  output logic        if_ready,
  output logic        id_valid,
  output logic [15:0] id_inst,
  output logic [15:0] id_pcadd2,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  logic [1:0]  count;
  logic        rd_ptr, wr_ptr;
  logic [15:0] inst_q [2];
  logic [15:0] pc_q [2];
  logic        f, s, push, pop;
  assign f         = flush === 1'b1;
  assign s         = id_stall === 1'b1;
  assign if_ready  = count != 2'(DEPTH);
  assign id_valid  = count != 2'd0;
  assign id_inst   = id_valid ? inst_q[rd_ptr] : NOP_INST;
  assign id_pcadd2 = id_valid ? pc_q[rd_ptr] : 16'h0000;
  assign push      = if_valid & if_ready & ~f;
  assign pop       = id_valid & ~s & ~f;
  // occupancy and pointers; flush empties the buffer and rewinds both pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else if (f) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      count  <= count + {1'b0, push} - {1'b0, pop};
      rd_ptr <= rd_ptr ^ pop;
      wr_ptr <= wr_ptr ^ push;
    end
  end
  // entry storage, written at the tail on every accepted push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q[0] <= 16'h0000;
      inst_q[1] <= 16'h0000;
      pc_q[0]   <= 16'h0000;
      pc_q[1]   <= 16'h0000;
    end else if (push) begin
      inst_q[wr_ptr] <= if_inst;
      pc_q[wr_ptr]   <= if_pcadd2;
    end
  end
`ifdef IFID_PERF_CNT_EN
  logic [15:0] stall_q, flush_q;
  // saturating counters: decode-stall cycles with a real head, and flushes that discard entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      stall_q <= stall_q + 16'(id_valid & s & ~f & ~&stall_q);
      flush_q <= flush_q + 16'(f & id_valid & ~&flush_q);
    end
  end
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: scoreboard bench for the IF/ID skid buffer
module tb_if_id_skid_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [15:0] if_inst = 16'h0000;
  logic [15:0] if_pcadd2 = 16'h0000;
  logic        id_stall = 1'b0;
  logic        flush = 1'b0;
  logic        if_ready, id_valid;
  logic [15:0] id_inst, id_pcadd2, stall_cnt, flush_cnt;
  logic [31:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
`ifdef IFID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  if_id_skid_reg dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst),
    .if_pcadd2(if_pcadd2), .id_stall(id_stall), .flush(flush),
    .if_ready(if_ready), .id_valid(id_valid), .id_inst(id_inst),
    .id_pcadd2(id_pcadd2), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] inst, input logic [15:0] pc, input bool_push);
    if_valid  = v;
    if_inst   = inst;
    if_pcadd2 = pc;
    if (bool_push) exp_q.push_back({inst, pc});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_valid = 1'b0;
    id_stall = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    cyc();
    rst = 1'b0;
  endtask

  // monitor: every instruction decode accepts must be the oldest expected one
  always @(negedge clk) begin
    if (!rst && id_valid && !id_stall && !flush) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got %h/%h expected none at %0t", id_inst, id_pcadd2, $time);
      end else begin
        chk("pop_order", {id_inst, id_pcadd2}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // reset hold with fetch active
    if_valid = 1'b1;
    if_inst = 16'h1234;
    if_pcadd2 = 16'h0002;
    #1;
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst", 32'(id_inst), 32'h0800);
    chk("rst_id_pcadd2", 32'(id_pcadd2), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_cnts", {stall_cnt, flush_cnt}, 32'd0);
    cyc();
    cyc();
    chk("rst_hold_valid", 32'(id_valid), 32'd0);
    rst = 1'b0;
    drive(1'b1, 16'h1234, 16'h0002, 1'b1);
    cyc();
    chk("first_push_lat", {15'd0, id_valid, id_inst}, {15'd0, 1'b1, 16'h1234});
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    chk("drain_idle", 32'(id_valid), 32'd0);

    // streaming A,B,C with no stall: count never exceeds 1
    drive(1'b1, 16'h4001, 16'h0002, 1'b1);
    cyc();
    chk("stream_a", {id_inst, id_pcadd2}, {16'h4001, 16'h0002});
    drive(1'b1, 16'h4002, 16'h0004, 1'b1);
    cyc();
    chk("stream_b", {id_inst, id_pcadd2}, {16'h4002, 16'h0004});
    chk("stream_ready_b", 32'(if_ready), 32'd1);
    drive(1'b1, 16'h4003, 16'h0006, 1'b1);
    cyc();
    chk("stream_c", {15'd0, id_valid, id_inst}, {15'd0, 1'b1, 16'h4003});
    chk("stream_ready_c", 32'(if_ready), 32'd1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    chk("stream_nop", {15'd0, id_valid, id_inst}, {15'd0, 1'b0, 16'h0800});

    // stall fill: A,B fill the buffer, D ignored while full
    do_reset();
    id_stall = 1'b1;
    drive(1'b1, 16'h5001, 16'h0010, 1'b1);
    cyc();
    drive(1'b1, 16'h5002, 16'h0012, 1'b1);
    cyc();
    chk("full_not_ready", 32'(if_ready), 32'd0);
    drive(1'b1, 16'h5DDD, 16'h0014, 1'b0);
    cyc();
    chk("full_head_a", {id_inst, id_pcadd2}, {16'h5001, 16'h0010});
    chk("stall_cnt", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    id_stall = 1'b0;
    cyc();
    chk("after_pop_ready", 32'(if_ready), 32'd1);
    chk("after_pop_head_b", {id_inst, id_pcadd2}, {16'h5002, 16'h0012});
    cyc();
    chk("fill_drained", {15'd0, id_valid, id_inst}, {15'd0, 1'b0, 16'h0800});

    // push and pop together at count 1
    id_stall = 1'b1;
    drive(1'b1, 16'h6001, 16'h0020, 1'b1);
    cyc();
    id_stall = 1'b0;
    drive(1'b1, 16'h6002, 16'h0022, 1'b1);
    cyc();
    chk("pushpop_head_b", {15'd0, id_valid, id_inst}, {15'd0, 1'b1, 16'h6002});
    chk("pushpop_ready", 32'(if_ready), 32'd1);
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();

    // flush at count 2 with incoming C and stall: everything discarded
    id_stall = 1'b1;
    drive(1'b1, 16'h7001, 16'h0030, 1'b1);
    cyc();
    drive(1'b1, 16'h7002, 16'h0032, 1'b1);
    cyc();
    drive(1'b1, 16'h7003, 16'h0034, 1'b0);
    flush = 1'b1;
    exp_q.delete();
    cyc();
    chk("flush_valid", {15'd0, id_valid, id_inst}, {15'd0, 1'b0, 16'h0800});
    chk("flush_ready", 32'(if_ready), 32'd1);
    chk("flush_cnt", 32'(flush_cnt), PERF ? 32'd1 : 32'd0);
    flush = 1'b0;
    id_stall = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    cyc();
    chk("flush_c_dropped", 32'(id_valid), 32'd0);

    // async reset between edges while full
    id_stall = 1'b1;
    drive(1'b1, 16'h8001, 16'h0040, 1'b1);
    cyc();
    drive(1'b1, 16'h8002, 16'h0042, 1'b1);
    cyc();
    drive(1'b0, 16'h0000, 16'h0000, 1'b0);
    #5;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_valid", {15'd0, id_valid, id_inst}, {15'd0, 1'b0, 16'h0800});
    chk("async_ready", 32'(if_ready), 32'd1);
    chk("async_cnts", {stall_cnt, flush_cnt}, 32'd0);
    #1;
    rst = 1'b0;
    id_stall = 1'b0;
    cyc();
    chk("async_empty_after", 32'(id_valid), 32'd0);
    cyc();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
